// File: rtl/request_ctrl_if.sv
// Handshake bundle between the request controller, the datapath control unit and the memory port.
interface request_ctrl_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             ihit;
    logic             dhit;
    logic             cu_dren;
    logic             cu_dwen;
    logic             cu_halt;
    logic             iren;
    logic             dren;
    logic             dwen;
    logic             update_pc;
    logic             busy;
    logic             halted;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  ihit, dhit, cu_dren, cu_dwen, cu_halt,
        output iren, dren, dwen, update_pc, busy, halted, timeout_err, stall_cnt
    );

    modport slave (
        output ihit, dhit, cu_dren, cu_dwen, cu_halt,
        input  iren, dren, dwen, update_pc, busy, halted, timeout_err, stall_cnt
    );
endinterface

// File: rtl/request_ctrl.sv
// Memory request sequencer: one request in flight, draining halt, no-response watchdog
// and a saturating stall-cycle counter.
module request_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic           CLK,
    input  logic           RST,
    request_ctrl_if.master bus
);
    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {FETCH, DATA, HALTED, ERROR} state_t;

    state_t           state;
    logic             dren_q;
    logic             dwen_q;
    logic             halt_q;
    logic [CNT_W-1:0] stall_q;
    logic             waiting_c;
    logic             wd_fire_c;

    // A wait cycle is one where the memory owed a response this cycle and gave none.
    assign waiting_c = (state == FETCH && !bus.ihit) || (state == DATA && !bus.dhit);

    if (TIMEOUT > 0) begin : g_wd
        logic [WAIT_W-1:0] wait_cnt;
        logic              wait_inc_c;

        // Keep counting only while the run of misses continues in the same state.
        assign wait_inc_c = waiting_c && !wd_fire_c && !(state == FETCH && bus.cu_halt);
        assign wd_fire_c  = waiting_c && (wait_cnt == WAIT_W'(TIMEOUT - 1));

        always_ff @(posedge CLK) begin
            if (RST)             wait_cnt <= '0;
            else if (wait_inc_c) wait_cnt <= wait_cnt + WAIT_W'(1);
            else                 wait_cnt <= '0;
        end
    end else begin : g_no_wd
        assign wd_fire_c = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            halt_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            if (waiting_c && stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + CNT_W'(1);

            case (state)
                FETCH: begin
                    if (wd_fire_c) begin
                        state <= ERROR;
                    end else if (bus.cu_halt) begin
                        state <= HALTED;
                    end else if (bus.ihit && (bus.cu_dren || bus.cu_dwen)) begin
                        state  <= DATA;
                        dwen_q <= bus.cu_dwen;
                        dren_q <= bus.cu_dren && !bus.cu_dwen;
                    end
                end
                DATA: begin
                    if (wd_fire_c) begin
                        state  <= ERROR;
                        halt_q <= 1'b0;
                    end else if (bus.dhit) begin
                        state  <= halt_q ? HALTED : FETCH;
                        halt_q <= 1'b0;
                    end else if (bus.cu_halt) begin
                        halt_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Enables decode straight from registered state; the latched type only matters in DATA.
    assign bus.iren        = (state == FETCH);
    assign bus.dren        = (state == DATA) && dren_q;
    assign bus.dwen        = (state == DATA) && dwen_q;
    assign bus.busy        = (state == DATA);
    assign bus.halted      = (state == HALTED);
    assign bus.timeout_err = (state == ERROR);
    assign bus.stall_cnt   = stall_q;

    assign bus.update_pc = (state == FETCH && bus.ihit && !bus.cu_halt
                            && !bus.cu_dren && !bus.cu_dwen)
                         || (state == DATA && bus.dhit && !halt_q);
endmodule

// File: tb/tb_request_ctrl.sv
// Bench for request_ctrl: directed scenarios with literal expectations plus a random
// stream checked every cycle against a behavioural model.
module tb_request_ctrl;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;
    localparam int          SAT     = 15;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    request_ctrl_if #(.CNT_W(CNT_W)) bus ();

    request_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model: which phase the access is in, plus run lengths as plain integers.
    bit m_access, m_store, m_pend, m_stopped, m_failed;
    int m_idle, m_stalls;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) begin
        if (RST) begin
            m_access = 0; m_store = 0; m_pend = 0; m_stopped = 0; m_failed = 0;
            m_idle = 0; m_stalls = 0;
        end else if (!m_stopped && !m_failed) begin
            if (!m_access) begin
                if (!bus.ihit) begin
                    m_stalls++;
                    if (m_idle + 1 == TIMEOUT) m_failed = 1;
                    else if (bus.cu_halt) begin m_stopped = 1; m_idle = 0; end
                    else m_idle++;
                end else begin
                    m_idle = 0;
                    if (bus.cu_halt) m_stopped = 1;
                    else if (bus.cu_dren || bus.cu_dwen) begin
                        m_access = 1;
                        m_store  = bus.cu_dwen;
                    end
                end
            end else begin
                if (!bus.dhit) begin
                    m_stalls++;
                    if (m_idle + 1 == TIMEOUT) m_failed = 1;
                    else begin
                        m_idle++;
                        if (bus.cu_halt) m_pend = 1;
                    end
                end else begin
                    m_access = 0;
                    m_idle   = 0;
                    if (m_pend) m_stopped = 1;
                    m_pend = 0;
                end
            end
        end
    end

    // Every-cycle comparison of the whole output bundle against the model.
    always @(negedge CLK) begin
        if (cmp_en) begin
            bit active, e_iren, e_dren, e_dwen, e_upc;
            int e_cnt;
            active = !m_stopped && !m_failed;
            e_iren = active && !m_access;
            e_dren = active && m_access && !m_store;
            e_dwen = active && m_access && m_store;
            e_upc  = (e_iren && bus.ihit && !bus.cu_halt && !bus.cu_dren && !bus.cu_dwen)
                  || (active && m_access && bus.dhit && !m_pend);
            e_cnt  = (m_stalls > SAT) ? SAT : m_stalls;
            chk("model_outputs",
                32'({bus.iren, bus.dren, bus.dwen, bus.update_pc, bus.busy, bus.halted,
                     bus.timeout_err, bus.stall_cnt}),
                32'({e_iren, e_dren, e_dwen, e_upc, active && m_access, m_stopped,
                     m_failed, CNT_W'(e_cnt)}));
        end
    end

    // One clock cycle: apply inputs after the edge, return mid-cycle for checking.
    task automatic cyc(input bit r, input bit ih, input bit dh, input bit dr, input bit dw,
                       input bit h);
        @(posedge CLK);
        #1;
        RST = r; bus.ihit = ih; bus.dhit = dh;
        bus.cu_dren = dr; bus.cu_dwen = dw; bus.cu_halt = h;
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        bus.ihit = 0; bus.dhit = 0; bus.cu_dren = 0; bus.cu_dwen = 0; bus.cu_halt = 0;

        // Reset then a fetch-only stream
        cyc(1, 0, 0, 0, 0, 0);
        cmp_en = 1'b1;
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0, 0, 0);
            chk("fetch_upc", 32'(bus.update_pc), 1);
            chk("fetch_iren", 32'(bus.iren), 1);
            if (i == 0) begin
                chk("rst_stall", 32'(bus.stall_cnt), 0);
                chk("rst_err", 32'(bus.timeout_err), 0);
                chk("rst_denables", 32'({bus.dren, bus.dwen}), 0);
            end
        end
        cyc(0, 0, 0, 0, 0, 0);
        chk("fetch_idle_upc", 32'(bus.update_pc), 0);

        // Load with three wait cycles
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("load_req_upc", 32'(bus.update_pc), 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("load_wait_en", 32'({bus.iren, bus.dren, bus.dwen}), 32'b010);
            chk("load_wait_upc", 32'(bus.update_pc), 0);
        end
        cyc(0, 0, 1, 0, 0, 0);
        chk("load_dhit_upc", 32'(bus.update_pc), 1);
        chk("load_stall", 32'(bus.stall_cnt), 3);
        cyc(0, 0, 0, 0, 0, 0);
        chk("load_after_en", 32'({bus.iren, bus.dren, bus.dwen}), 32'b100);

        // Halt arriving while a store is outstanding
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1);
        chk("store_dwen", 32'({bus.iren, bus.dren, bus.dwen, bus.busy}), 32'b0011);
        cyc(0, 0, 1, 0, 0, 0);
        chk("store_halt_upc", 32'(bus.update_pc), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("store_halted", 32'({bus.halted, bus.iren, bus.dren, bus.dwen}), 32'b1000);
        cyc(0, 1, 0, 0, 0, 0);
        chk("halted_ignores_ihit", 32'({bus.update_pc, bus.halted}), 32'b01);

        // Both request bits set, then halt beating a load in FETCH
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, 0);
        chk("both_req_upc", 32'(bus.update_pc), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("both_store_wins", 32'({bus.dren, bus.dwen}), 32'b01);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 1);
        chk("halt_ihit_upc", 32'(bus.update_pc), 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("halt_no_dren", 32'({bus.halted, bus.dren, bus.busy}), 32'b100);

        // Watchdog at TIMEOUT=4, then recovery
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0);
        chk("wd_not_yet", 32'({bus.timeout_err, bus.iren}), 32'b01);
        cyc(0, 0, 0, 0, 0, 0);
        chk("wd_fired", 32'({bus.timeout_err, bus.iren, bus.dren, bus.dwen}), 32'b1000);
        chk("wd_stall", 32'(bus.stall_cnt), 4);
        cyc(0, 1, 0, 0, 0, 0);
        chk("wd_sticky", 32'({bus.timeout_err, bus.update_pc}), 32'b10);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("wd_recover", 32'({bus.timeout_err, bus.iren, bus.stall_cnt}), 32'b01_0000);

        // Stall counter saturation: 18 wait cycles into a 4-bit counter
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 3; j++) cyc(0, 0, 0, 0, 0, 0);
            cyc(0, 1, 0, 0, 0, 0);
        end
        cyc(0, 1, 0, 0, 0, 0);
        chk("stall_saturate", 32'(bus.stall_cnt), 15);

        // Random stream
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) == 0)
             || ((m_stopped || m_failed) && $urandom_range(0, 7) == 0);
            cyc(r, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5,
                $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                $urandom_range(0, 29) == 0);
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/request_ctrl.md
# request_ctrl

Parametrised memory request controller between the datapath control unit and the single-port memory/cache interface. It sequences instruction fetches and load/store accesses and generates the PC-update strobe. It extends the basic request unit with three additions: an explicit state machine that keeps only one memory request in flight, a halt that drains an outstanding data access before halting, and a configurable watchdog that flags a memory that never responds. It also provides a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- TIMEOUT, default 255: consecutive no-hit cycles in one wait state before ERROR. 0 disables the watchdog.
- CNT_W, default 16: width of the stall counter.

Ports:
- CLK  in  1  system clock. All state updates on the rising edge.
- RST  in  1  reset. Synchronous and active-high.
- ihit  in  1  instruction memory returned data this cycle.
- dhit  in  1  data memory completed the access this cycle.
- cu_dren  in  1  the decoded instruction requests a load.
- cu_dwen  in  1  the decoded instruction requests a store.
- cu_halt  in  1  the decoded instruction is halt.
- iren  out  1  instruction read enable (registered).
- dren  out  1  data read enable (registered).
- dwen  out  1  data write enable (registered).
- update_pc  out  1  PC advance strobe (combinational).
- busy  out  1  high while a data access is outstanding (state DATA).
- halted  out  1  high in state HALTED.
- timeout_err  out  1  high in state ERROR. Sticky until RST.
- stall_cnt  out  CNT_W  saturating count of wait cycles.

## Operation
- States: FETCH, DATA, HALTED, ERROR. Encoding is free.
- Outputs are decoded from the registered state:
  - FETCH: iren=1.
  - DATA: dren or dwen per the latched request.
  - HALTED and ERROR: all enables 0.
- Exactly one of iren/dren/dwen is high at a time, or none.
- FETCH transitions, by priority:
  - cu_halt=1 → HALTED (no data access issued, update_pc=0).
  - Else ihit=1 and (cu_dren or cu_dwen) → DATA. Latch dwen_q=cu_dwen and dren_q=cu_dren and not cu_dwen; a store wins if both are set. update_pc=0.
  - Else ihit=1 → stay in FETCH, update_pc=1.
  - Else stay in FETCH.
- DATA transitions:
  - dhit=1 → FETCH, update_pc=1.
  - halt_q=1 on dhit → HALTED instead, update_pc=0.
- halt_q is set when cu_halt=1 is seen while in DATA. It is cleared when leaving DATA.
- HALTED and ERROR are terminal. Only RST leaves them.
- The idle hit is ignored in each state: dhit in FETCH and ihit in DATA have no effect.
- Watchdog:
  - wait_cnt has width $clog2(TIMEOUT+1).
  - It increments each cycle in FETCH with ihit=0, or in DATA with dhit=0.
  - It clears on any hit or state change.
  - If wait_cnt==TIMEOUT-1 and still no hit, go to ERROR next edge. This takes priority over a halt.
  - With TIMEOUT=0 the counter and ERROR are removed.
- stall_cnt increments in the same cycles as wait_cnt. It saturates at 2^CNT_W-1 and does not wrap.

## Timing
- RST=1 at an edge sets the following, overriding everything including mid-access:
  - State FETCH; iren=1, dren=0, dwen=0.
  - busy=0, halted=0, timeout_err=0.
  - wait_cnt=0, stall_cnt=0, halt_q=0.
- update_pc is asserted in the same cycle as the qualifying hit. It is never high for two cycles per instruction.
- Data request latency: dren/dwen rise on the edge after the ihit that carried the request. They fall on the edge after dhit.
- iren falls with entry to DATA and rises again the cycle after dhit.
- Back-to-back fetches: iren stays high. update_pc pulses on every ihit.
- Watchdog: after exactly TIMEOUT consecutive no-hit cycles, timeout_err=1 from the next edge.

## Test plan
- Reset: hold RST 2 cycles → iren=1, dren=dwen=0, stall_cnt=0, timeout_err=0.
- Fetch-only stream: ihit=1 for 4 cycles with no data request → update_pc high 4 cycles, iren stays 1, state FETCH.
- Load with 3-cycle wait: ihit with cu_dren=1, then dhit on the 4th DATA cycle:
  - next cycle iren=0, dren=1;
  - update_pc=1 only in the dhit cycle;
  - stall_cnt=3;
  - the edge after dhit gives iren=1.
- Halt during a store: cu_dwen+ihit, then cu_halt=1 while in DATA, then dhit → update_pc=0, the edge after dhit gives halted=1 and all enables 0.
- Simultaneous events, with cu_dren and cu_dwen both set:
  - ihit → dwen=1, dren=0;
  - cu_halt+ihit+cu_dren in FETCH → HALTED, no dren.
- Watchdog with TIMEOUT=4: ihit held 0 → timeout_err=1 after 4 cycles, enables 0; a later ihit is ignored; RST recovers to FETCH.
